trigger_chain_cfg_sequencer: RTL and testbench

//  Wishbone master that programs the trigger chain (biquad-notch coefficients, AGC settings) from a

---
 rtl/trigger_chain_cfg_sequencer.sv | 178 +++++++++++++++++
 tb/tb_trigger_chain_cfg_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_chain_cfg_sequencer.sv
// trigger_chain_cfg_sequencer
// Wishbone master that walks a table of write entries and programs the biquad-notch
// and AGC register ports of the trigger chain, one non-pipelined write at a time.
// Each table entry is {tgt, adr[21:0], dat[31:0]}; tgt=0 selects biquad, tgt=1 selects AGC.

module trigger_chain_cfg_sequencer #(
    parameter int TBL_AW  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [TBL_AW:0]   num_entries_i,
    output logic [TBL_AW-1:0] tbl_addr_o,
    input  logic [54:0]       tbl_data_i,
    output logic              wb_bq_cyc_o,
    output logic              wb_bq_stb_o,
    output logic              wb_bq_we_o,
    output logic [21:0]       wb_bq_adr_o,
    output logic [31:0]       wb_bq_dat_o,
    output logic [3:0]        wb_bq_sel_o,
    input  logic              wb_bq_ack_i,
    output logic              wb_agc_cyc_o,
    output logic              wb_agc_stb_o,
    output logic              wb_agc_we_o,
    output logic [21:0]       wb_agc_adr_o,
    output logic [31:0]       wb_agc_dat_o,
    output logic [3:0]        wb_agc_sel_o,
    input  logic              wb_agc_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [TBL_AW-1:0] err_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_WRITE, S_NEXT, S_DONE
    } state_e;

    // Largest legal entry count; larger requests are clamped to it.
    localparam logic [TBL_AW:0] MAX_CNT = {1'b1, {TBL_AW{1'b0}}};
    // Wait-counter value at which a write without ack is abandoned.
    localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [TBL_AW:0]     idx_q;
    logic [TBL_AW:0]     count_q;
    logic [TBL_AW-1:0]   tbl_addr_q;
    logic                tgt_q;
    logic [21:0]         adr_q;
    logic [31:0]         dat_q;
    logic [15:0]         wait_q;
    logic                abort_q;
    logic                err_q;
    logic [TBL_AW-1:0]   err_idx_q;

    logic                sel_ack;
    logic [TBL_AW:0]     idx_inc;
    logic                last_entry;
    logic                timeout_hit;
    logic                start_accept;

    // Only the ack of the port currently addressed can complete a write.
    assign sel_ack      = tgt_q ? wb_agc_ack_i : wb_bq_ack_i;
    assign idx_inc      = idx_q + 1'b1;
    assign last_entry   = (idx_inc == count_q);
    assign timeout_hit  = !sel_ack && (wait_q == TO_LAST);
    assign start_accept = (state_q == S_IDLE) && start_i;

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; timeout is checked before the pending abort is ever looked at.
    // NOTE: the default assignment at the top keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = (num_entries_i == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_WRITE;
            S_WRITE: begin
                if (sel_ack)          state_d = S_NEXT;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_NEXT:  state_d = (last_entry || abort_q || abort_i) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: entry count, index, table address, latched entry, wait counter, flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            idx_q      <= '0;
            count_q    <= '0;
            tbl_addr_q <= '0;
            tgt_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            wait_q     <= '0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            if (start_accept) begin
                count_q <= (num_entries_i > MAX_CNT) ? MAX_CNT : num_entries_i;
                idx_q   <= '0;
                err_q   <= 1'b0;
            end
            // Address is presented for the whole FETCH cycle and then held.
            if (state_d == S_FETCH)
                tbl_addr_q <= (state_q == S_NEXT) ? idx_inc[TBL_AW-1:0] : '0;
            if (state_q == S_LATCH)
                {tgt_q, adr_q, dat_q} <= tbl_data_i;
            wait_q <= (state_q == S_WRITE) ? wait_q + 16'd1 : 16'd0;
            if ((state_q == S_WRITE) && timeout_hit) begin
                err_q     <= 1'b1;
                err_idx_q <= idx_q[TBL_AW-1:0];
            end
            if (state_q == S_NEXT)
                idx_q <= idx_inc;
            // Abort is remembered while busy and only acted on between writes.
            if (state_q == S_IDLE) abort_q <= 1'b0;
            else if (abort_i)      abort_q <= 1'b1;
        end
    end

    // Output decode: the addressed port carries the write, the other stays all-zero.
    always_comb begin
        wb_bq_cyc_o  = 1'b0;
        wb_bq_stb_o  = 1'b0;
        wb_bq_we_o   = 1'b0;
        wb_bq_adr_o  = '0;
        wb_bq_dat_o  = '0;
        wb_bq_sel_o  = '0;
        wb_agc_cyc_o = 1'b0;
        wb_agc_stb_o = 1'b0;
        wb_agc_we_o  = 1'b0;
        wb_agc_adr_o = '0;
        wb_agc_dat_o = '0;
        wb_agc_sel_o = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            S_FETCH, S_LATCH, S_NEXT: busy_o = 1'b1;
            S_WRITE: begin
                busy_o = 1'b1;
                if (tgt_q) begin
                    wb_agc_cyc_o = 1'b1;
                    wb_agc_stb_o = 1'b1;
                    wb_agc_we_o  = 1'b1;
                    wb_agc_adr_o = adr_q;
                    wb_agc_dat_o = dat_q;
                    wb_agc_sel_o = 4'hF;
                end else begin
                    wb_bq_cyc_o  = 1'b1;
                    wb_bq_stb_o  = 1'b1;
                    wb_bq_we_o   = 1'b1;
                    wb_bq_adr_o  = adr_q;
                    wb_bq_dat_o  = dat_q;
                    wb_bq_sel_o  = 4'hF;
                end
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign tbl_addr_o = tbl_addr_q;
    assign err_o      = err_q;
    assign err_idx_o  = err_idx_q;

endmodule

// File: tb/tb_trigger_chain_cfg_sequencer.sv
// Directed testbench for trigger_chain_cfg_sequencer: table model with one-cycle read
// latency, two wishbone slave models with programmable ack delay, and write loggers.

module tb_trigger_chain_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [6:0]  num_entries;
    logic [5:0]  tbl_addr;
    logic [54:0] tbl_data;
    logic        bq_cyc, bq_stb, bq_we, bq_ack;
    logic [21:0] bq_adr;
    logic [31:0] bq_dat;
    logic [3:0]  bq_sel;
    logic        agc_cyc, agc_stb, agc_we, agc_ack;
    logic [21:0] agc_adr;
    logic [31:0] agc_dat;
    logic [3:0]  agc_sel;
    logic        busy, done, err;
    logic [5:0]  err_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trigger_chain_cfg_sequencer #(.TBL_AW(6), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
        .num_entries_i(num_entries), .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
        .wb_bq_cyc_o(bq_cyc), .wb_bq_stb_o(bq_stb), .wb_bq_we_o(bq_we),
        .wb_bq_adr_o(bq_adr), .wb_bq_dat_o(bq_dat), .wb_bq_sel_o(bq_sel), .wb_bq_ack_i(bq_ack),
        .wb_agc_cyc_o(agc_cyc), .wb_agc_stb_o(agc_stb), .wb_agc_we_o(agc_we),
        .wb_agc_adr_o(agc_adr), .wb_agc_dat_o(agc_dat), .wb_agc_sel_o(agc_sel), .wb_agc_ack_i(agc_ack),
        .busy_o(busy), .done_o(done), .err_o(err), .err_idx_o(err_idx)
    );

    // Table model: data appears one cycle after the address.
    logic [54:0] tbl_mem [64];
    always @(posedge clk) tbl_data <= tbl_mem[tbl_addr];

    // Slave models: ack for one cycle after seeing stb on `delay` edges.
    int   bq_delay = 1, agc_delay = 1;
    bit   bq_never = 0, agc_never = 0;
    logic bq_ack_m = 1'b0, agc_ack_m = 1'b0;
    logic bq_spur = 1'b0, agc_spur = 1'b0;
    int   bq_cnt = 0, agc_cnt = 0;
    assign bq_ack  = bq_ack_m | bq_spur;
    assign agc_ack = agc_ack_m | agc_spur;

    always @(posedge clk) begin
        bq_ack_m <= 1'b0;
        if (bq_stb && !bq_ack_m && !bq_never) begin
            if (bq_cnt == bq_delay - 1) begin bq_ack_m <= 1'b1; bq_cnt <= 0; end
            else bq_cnt <= bq_cnt + 1;
        end else bq_cnt <= 0;
    end

    always @(posedge clk) begin
        agc_ack_m <= 1'b0;
        if (agc_stb && !agc_ack_m && !agc_never) begin
            if (agc_cnt == agc_delay - 1) begin agc_ack_m <= 1'b1; agc_cnt <= 0; end
            else agc_cnt <= agc_cnt + 1;
        end else agc_cnt <= 0;
    end

    // Bus monitor: write logs, strobe cycle counts, minimum cyc-low gap, port overlap.
    logic [53:0] bq_log[$];
    logic [53:0] agc_log[$];
    int bq_stb_cyc, agc_stb_cyc, min_gap, low_run, cyc_cnt = 0;
    bit seen_write, prev_cyc, overlap;

    always @(posedge clk) begin
        cyc_cnt++;
        if (bq_cyc && bq_stb) bq_stb_cyc++;
        if (agc_cyc && agc_stb) agc_stb_cyc++;
        if (bq_cyc && bq_stb && bq_we && bq_ack && bq_sel == 4'hF) bq_log.push_back({bq_adr, bq_dat});
        if (agc_cyc && agc_stb && agc_we && agc_ack && agc_sel == 4'hF) agc_log.push_back({agc_adr, agc_dat});
        if (bq_cyc && agc_cyc) overlap = 1'b1;
        if (bq_cyc || agc_cyc) begin
            if (!prev_cyc && seen_write && low_run < min_gap) min_gap = low_run;
            seen_write = 1'b1;
            low_run    = 0;
        end else begin
            low_run++;
        end
        prev_cyc = bq_cyc || agc_cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        bq_log.delete();
        agc_log.delete();
        bq_stb_cyc  = 0;
        agc_stb_cyc = 0;
        min_gap     = 1000;
        seen_write  = 1'b0;
        overlap     = 1'b0;
    endtask

    // Pulse start for one cycle; returns the cycle stamp of the accepting edge.
    task automatic start_seq(input logic [6:0] n, output int t0);
        num_entries = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc_cnt;
    endtask

    // Bounded wait for done_o; ok=0 if the bound expired.
    task automatic wait_done(input int limit, output bit ok);
        int k = 0;
        while (!done && k < limit) begin tick(); k++; end
        ok = done;
    endtask

    task automatic wait_bq_stb(output bit ok);
        int k = 0;
        while (!bq_stb && k < 50) begin tick(); k++; end
        ok = bq_stb;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_entries = '0;
        repeat (3) tick();
        checks++;
        if ({busy, done, err, bq_cyc, bq_stb, agc_cyc, agc_stb} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {busy, done, err, bq_cyc, bq_stb, agc_cyc, agc_stb});
        end
        checks++;
        if (tbl_addr !== 6'd0 || err_idx !== 6'd0) begin
            failures++;
            $display("FAIL reset_addr: tbl_addr=%0d err_idx=%0d required 0/0", tbl_addr, err_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int t0; bit ok;
        tbl_mem[0] = {1'b0, 22'h10, 32'hA0A0_0001};
        tbl_mem[1] = {1'b1, 22'h04, 32'hB0B0_0002};
        tbl_mem[2] = {1'b0, 22'h11, 32'hC0C0_0003};
        bq_delay = 1; agc_delay = 1;
        clear_logs();
        start_seq(7'd3, t0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_done(100, ok);
        checks++;
        if (!ok || cyc_cnt - t0 != 15) begin
            failures++;
            $display("FAIL basic_latency: done=%b cycles=%0d required 1/15", ok, cyc_cnt - t0);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_flags: busy=%b err=%b required 0/0", busy, err);
        end
        checks++;
        if (bq_log.size() != 2 || agc_log.size() != 1) begin
            failures++;
            $display("FAIL basic_counts: bq=%0d agc=%0d required 2/1", bq_log.size(), agc_log.size());
        end else begin
            checks++;
            if (bq_log[0] !== {22'h10, 32'hA0A0_0001} || bq_log[1] !== {22'h11, 32'hC0C0_0003}) begin
                failures++;
                $display("FAIL basic_bq_data: got %h %h required 00010a0a00001 00011c0c00003",
                         bq_log[0], bq_log[1]);
            end
            checks++;
            if (agc_log[0] !== {22'h04, 32'hB0B0_0002}) begin
                failures++;
                $display("FAIL basic_agc_data: got %h required %h", agc_log[0], {22'h04, 32'hB0B0_0002});
            end
        end
        checks++;
        if (min_gap != 3 || overlap) begin
            failures++;
            $display("FAIL basic_gap: min_gap=%0d overlap=%b required 3/0", min_gap, overlap);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_zero_entries();
        int t0;
        clear_logs();
        start_seq(7'd0, t0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done=%b busy=%b required 1/0", done, busy);
        end
        tick();
        tick();
        checks++;
        if (bq_stb_cyc != 0 || agc_stb_cyc != 0 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_bus: bq_stb=%0d agc_stb=%0d done=%b required 0/0/0",
                     bq_stb_cyc, agc_stb_cyc, done);
        end
    endtask

    task automatic test_timeout();
        int t0; bit ok;
        tbl_mem[0] = {1'b0, 22'h20, 32'h0000_0100};
        tbl_mem[1] = {1'b0, 22'h21, 32'h0000_0101};
        tbl_mem[2] = {1'b1, 22'h22, 32'h0000_0102};
        tbl_mem[3] = {1'b0, 22'h23, 32'h0000_0103};
        agc_never = 1'b1;
        clear_logs();
        start_seq(7'd4, t0);
        wait_done(100, ok);
        checks++;
        if (!ok || cyc_cnt - t0 != 20) begin
            failures++;
            $display("FAIL timeout_latency: done=%b cycles=%0d required 1/20", ok, cyc_cnt - t0);
        end
        checks++;
        if (agc_stb_cyc != 8) begin
            failures++;
            $display("FAIL timeout_stb_len: got %0d required 8", agc_stb_cyc);
        end
        checks++;
        if (err !== 1'b1 || err_idx !== 6'd2) begin
            failures++;
            $display("FAIL timeout_err: err=%b idx=%0d required 1/2", err, err_idx);
        end
        checks++;
        if (bq_log.size() != 2 || tbl_addr !== 6'd2) begin
            failures++;
            $display("FAIL timeout_no_next: bq=%0d tbl_addr=%0d required 2/2", bq_log.size(), tbl_addr);
        end
        agc_never = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int t0, k; bit ok;
        tbl_mem[0] = {1'b0, 22'h30, 32'h0000_0200};
        tbl_mem[1] = {1'b0, 22'h31, 32'h0000_0201};
        tbl_mem[2] = {1'b0, 22'h32, 32'h0000_0202};
        bq_delay = 5;
        clear_logs();
        start_seq(7'd3, t0);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL abort_err_clear: got %b required 0", err); end
        k = 0;
        while (bq_log.size() < 1 && k < 100) begin tick(); k++; end
        wait_bq_stb(ok);
        checks++;
        if (!ok || tbl_addr !== 6'd1) begin
            failures++;
            $display("FAIL abort_reach_entry1: stb=%b tbl_addr=%0d required 1/1", ok, tbl_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(100, ok);
        checks++;
        if (!ok || bq_log.size() != 2) begin
            failures++;
            $display("FAIL abort_writes: done=%b bq=%0d required 1/2", ok, bq_log.size());
        end else begin
            checks++;
            if (bq_log[1] !== {22'h31, 32'h0000_0201} || tbl_addr !== 6'd1 || err !== 1'b0) begin
                failures++;
                $display("FAIL abort_state: last=%h tbl_addr=%0d err=%b required %h/1/0",
                         bq_log[1], tbl_addr, err, {22'h31, 32'h0000_0201});
            end
        end
        bq_delay = 1;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int t0, k; bit ok;
        tbl_mem[0] = {1'b0, 22'h40, 32'h0000_0300};
        tbl_mem[1] = {1'b0, 22'h41, 32'h0000_0301};
        bq_delay = 5;
        clear_logs();
        start_seq(7'd2, t0);
        k = 0;
        while (bq_log.size() < 1 && k < 100) begin tick(); k++; end
        wait_bq_stb(ok);
        rst = 1'b1;
        tick();
        checks++;
        if (!ok || {bq_cyc, bq_stb, agc_cyc, agc_stb, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_write: stb_seen=%b outs=%b required 1/00000",
                     ok, {bq_cyc, bq_stb, agc_cyc, agc_stb, busy});
        end
        rst = 1'b0;
        bq_delay = 1;
        tick();
        clear_logs();
        start_seq(7'd2, t0);
        checks++;
        if (tbl_addr !== 6'd0) begin
            failures++;
            $display("FAIL rst_restart_addr: got %0d required 0", tbl_addr);
        end
        wait_done(100, ok);
        checks++;
        if (!ok || bq_log.size() != 2 || cyc_cnt - t0 != 10) begin
            failures++;
            $display("FAIL rst_restart_run: done=%b bq=%0d cycles=%0d required 1/2/10",
                     ok, bq_log.size(), cyc_cnt - t0);
        end else begin
            checks++;
            if (bq_log[0] !== {22'h40, 32'h0000_0300}) begin
                failures++;
                $display("FAIL rst_restart_first: got %h required %h", bq_log[0], {22'h40, 32'h0000_0300});
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int t0; bit ok;
        tbl_mem[0] = {1'b0, 22'h10, 32'hA0A0_0001};
        tbl_mem[1] = {1'b1, 22'h04, 32'hB0B0_0002};
        tbl_mem[2] = {1'b0, 22'h11, 32'hC0C0_0003};
        clear_logs();
        start_seq(7'd3, t0);
        // A second start with a different count while busy must do nothing.
        num_entries = 7'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_bq_stb(ok);
        // Ack on the idle AGC port during the biquad write must be ignored.
        agc_spur = 1'b1;
        tick();
        agc_spur = 1'b0;
        wait_done(100, ok);
        checks++;
        if (!ok || cyc_cnt - t0 != 15) begin
            failures++;
            $display("FAIL b2b_latency: done=%b cycles=%0d required 1/15", ok, cyc_cnt - t0);
        end
        checks++;
        if (bq_log.size() != 2 || agc_log.size() != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_writes: bq=%0d agc=%0d err=%b required 2/1/0",
                     bq_log.size(), agc_log.size(), err);
        end
        tick();
    endtask

    task automatic test_saturate();
        int t0; bit ok;
        for (int i = 0; i < 64; i++) tbl_mem[i] = {1'b0, 22'(i), 32'(i * 3)};
        clear_logs();
        start_seq(7'd100, t0);
        wait_done(1000, ok);
        checks++;
        if (!ok || bq_log.size() != 64 || cyc_cnt - t0 != 320) begin
            failures++;
            $display("FAIL sat_count: done=%b bq=%0d cycles=%0d required 1/64/320",
                     ok, bq_log.size(), cyc_cnt - t0);
        end else begin
            checks++;
            if (bq_log[63] !== {22'd63, 32'd189} || tbl_addr !== 6'd63) begin
                failures++;
                $display("FAIL sat_last: got %h addr=%0d required %h/63", bq_log[63], tbl_addr,
                         {22'd63, 32'd189});
            end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbl_mem[i] = '0;
        test_reset();
        test_basic();
        test_zero_entries();
        test_timeout();
        test_abort();
        test_reset_mid_write();
        test_back_to_back();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
